// File: rtl/regr_pipe.sv
// rtl/regr_pipe.sv - elastic multi-stage pipeline register with per-stage skid buffers
// Every stage is a main register plus a one-entry skid, so each ready is a flop output.
module regr_pipe #(
  parameter int            N         = 32,
  parameter int            STAGES    = 1,
  parameter logic [N-1:0]  RESET_VAL = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [N-1:0]                     in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [N-1:0]                     out_data,
  output logic [$clog2(2*STAGES+1)-1:0]    occupancy
);

  localparam int OW = $clog2(2*STAGES+1);

  logic [STAGES-1:0] main_v_q, main_v_d;
  logic [STAGES-1:0] skid_v_q, skid_v_d;
  logic [N-1:0]      main_d_q [STAGES];
  logic [N-1:0]      main_d_d [STAGES];
  logic [N-1:0]      skid_d_q [STAGES];
  logic [N-1:0]      skid_d_d [STAGES];

  logic [STAGES-1:0] up_valid;
  logic [STAGES-1:0] dn_ready;
  logic [N-1:0]      up_data  [STAGES];
  logic [STAGES-1:0] stage_acc;
  logic [STAGES-1:0] stage_emit;

  logic [OW-1:0]     occ_q, occ_d;
  logic              accept;
  logic              emit;

  // Stage k is fed by stage k-1's main register; its ready is stage k+1's empty skid.
  always_comb begin
    up_valid[0]        = in_valid;
    up_data[0]         = in_data;
    dn_ready[STAGES-1] = out_ready;
    for (int k = 1; k < STAGES; k++) begin
      up_valid[k]   = main_v_q[k-1];
      up_data[k]    = main_d_q[k-1];
      dn_ready[k-1] = !skid_v_q[k];
    end
  end

  assign stage_acc  = up_valid & ~skid_v_q;
  assign stage_emit = main_v_q & dn_ready;

  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d_d = main_d_q;
    skid_d_d = skid_d_q;
    for (int k = 0; k < STAGES; k++) begin
      if (!main_v_q[k]) begin
        if (stage_acc[k]) begin
          main_v_d[k] = 1'b1;
          main_d_d[k] = up_data[k];
        end
      end else if (stage_emit[k]) begin
        // A full skid always drains into main first; ready was low so nothing new arrives.
        if (skid_v_q[k]) begin
          main_d_d[k] = skid_d_q[k];
          skid_v_d[k] = 1'b0;
        end else if (stage_acc[k]) begin
          main_d_d[k] = up_data[k];
        end else begin
          main_v_d[k] = 1'b0;
        end
      end else if (stage_acc[k]) begin
        skid_v_d[k] = 1'b1;
        skid_d_d[k] = up_data[k];
      end
    end
  end

  assign in_ready  = !skid_v_q[0];
  assign out_valid = main_v_q[STAGES-1];
  assign out_data  = main_d_q[STAGES-1];
  assign occupancy = occ_q;
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;

  always_comb begin
    occ_d = occ_q;
    if (accept && !emit) begin
      occ_d = occ_q + OW'(1);
    end else if (!accept && emit) begin
      occ_d = occ_q - OW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_v_q <= '0;
      skid_v_q <= '0;
      occ_q    <= '0;
      for (int k = 0; k < STAGES; k++) begin
        main_d_q[k] <= RESET_VAL;
        skid_d_q[k] <= RESET_VAL;
      end
    end else if (flush) begin
      main_v_q <= '0;
      skid_v_q <= '0;
      occ_q    <= '0;
      for (int k = 0; k < STAGES; k++) begin
        main_d_q[k] <= RESET_VAL;
        skid_d_q[k] <= RESET_VAL;
      end
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      occ_q    <= occ_d;
      for (int k = 0; k < STAGES; k++) begin
        main_d_q[k] <= main_d_d[k];
        skid_d_q[k] <= skid_d_d[k];
      end
    end
  end

endmodule

// File: tb/tb_regr_pipe.sv
// tb/tb_regr_pipe.sv - directed and scoreboard bench for regr_pipe
// Three instances: STAGES=1/N=8/RESET_VAL=FF, STAGES=2/N=8, STAGES=3/N=16.
module tb_regr_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       f1, iv1, ir1, ov1, or1;
  logic [7:0] id1, od1;
  logic [1:0] oc1;

  logic       f2, iv2, ir2, ov2, or2;
  logic [7:0] id2, od2;
  logic [2:0] oc2;

  logic        f3, iv3, ir3, ov3, or3;
  logic [15:0] id3, od3;
  logic [2:0]  oc3;

  regr_pipe #(.N(8), .STAGES(1), .RESET_VAL(8'hFF)) dut1 (
    .clk(clk), .rst(rst), .flush(f1), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .occupancy(oc1));

  regr_pipe #(.N(8), .STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .flush(f2), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .occupancy(oc2));

  regr_pipe #(.N(16), .STAGES(3)) dut3 (
    .clk(clk), .rst(rst), .flush(f3), .in_valid(iv3), .in_ready(ir3), .in_data(id3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3), .occupancy(oc3));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       fl;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic [2:0] e_oc;
  } vec_t;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  vec_t       vt [14];
  logic [7:0] q [$];
  logic [7:0] held;
  logic       hold_prev;
  int         nacc;

  initial begin
    // Cycle-by-cycle vectors for the 2-stage instance; expectations are the outputs
    // visible before the edge that consumes the listed inputs.
    vt[0]  = '{H, 8'h11, H, L, H, L, 8'h00, 3'd0};
    vt[1]  = '{H, 8'h22, H, L, H, L, 8'h00, 3'd1};
    vt[2]  = '{L, 8'h00, L, L, H, H, 8'h11, 3'd2};
    vt[3]  = '{H, 8'h33, L, L, H, H, 8'h11, 3'd2};
    vt[4]  = '{H, 8'h44, L, L, H, H, 8'h11, 3'd3};
    vt[5]  = '{H, 8'h5A, L, L, L, H, 8'h11, 3'd4};
    vt[6]  = '{H, 8'h66, H, L, L, H, 8'h11, 3'd4};
    vt[7]  = '{H, 8'h66, H, L, L, H, 8'h22, 3'd3};
    vt[8]  = '{H, 8'h66, L, L, H, H, 8'h33, 3'd2};
    vt[9]  = '{H, 8'h55, H, H, H, H, 8'h33, 3'd3};
    vt[10] = '{L, 8'h00, H, L, H, L, 8'h00, 3'd0};
    vt[11] = '{H, 8'h77, L, L, H, L, 8'h00, 3'd0};
    vt[12] = '{L, 8'h00, L, L, H, L, 8'h00, 3'd1};
    vt[13] = '{L, 8'h00, L, L, H, H, 8'h77, 3'd1};

    rst = 1'b0;
    {f1, iv1, or1, f2, iv2, or2, f3, iv3, or3} = '0;
    id1 = '0; id2 = '0; id3 = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset s1 out_valid", ov1, 0);
    chk("reset s1 out_data", od1, 8'hFF);
    chk("reset s1 in_ready", ir1, 1);
    chk("reset s1 occupancy", oc1, 0);
    chk("reset s2 out_data", od2, 0);
    chk("reset s3 occupancy", oc3, 0);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      iv2 = vt[i].iv; id2 = vt[i].id; or2 = vt[i].ordy; f2 = vt[i].fl;
      #1;
      chk($sformatf("vec%0d in_ready", i), ir2, vt[i].e_ir);
      chk($sformatf("vec%0d out_valid", i), ov2, vt[i].e_ov);
      chk($sformatf("vec%0d out_data", i), od2, vt[i].e_od);
      chk($sformatf("vec%0d occupancy", i), oc2, vt[i].e_oc);
    end

    // 1-stage stream 0x01..0x10 at full rate
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      iv1 = (c < 16); id1 = 8'(c + 1); or1 = 1'b1;
      #1;
      chk($sformatf("s1 c%0d out_valid", c), ov1, (c > 0 && c <= 16));
      chk($sformatf("s1 c%0d out_data", c), od1, (c == 0) ? 8'hFF : 8'((c > 16) ? 16 : c));
      chk($sformatf("s1 c%0d occupancy", c), oc1, (c > 0 && c <= 16) ? 1 : 0);
      chk($sformatf("s1 c%0d in_ready", c), ir1, 1);
    end
    @(negedge clk); iv1 = 1'b1; id1 = 8'h3C;
    @(negedge clk); iv1 = 1'b0; f1 = 1'b1;
    #1;
    chk("s1 pre-flush out_data", od1, 8'h3C);
    @(negedge clk); f1 = 1'b0;
    #1;
    chk("s1 flush out_valid", ov1, 0);
    chk("s1 flush out_data", od1, 8'hFF);
    chk("s1 flush occupancy", oc1, 0);
    chk("s1 flush in_ready", ir1, 1);

    // 3-stage fill against a stalled sink, then drain
    nacc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      or3 = 1'b0; iv3 = 1'b1; id3 = 16'hA000 + 16'(nacc);
      #1;
      chk($sformatf("s3 fill c%0d in_ready", c), ir3, (c < 6));
      chk($sformatf("s3 fill c%0d occupancy", c), oc3, (c < 6) ? c : 6);
      chk($sformatf("s3 fill c%0d out_valid", c), ov3, (c >= 3));
      if (ir3) nacc++;
    end
    chk("s3 accepts at full", nacc, 6);
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      or3 = 1'b1; iv3 = 1'b1; id3 = 16'hA000 + 16'(nacc);
      #1;
      chk($sformatf("s3 drain j%0d out_valid", j), ov3, 1);
      chk($sformatf("s3 drain j%0d out_data", j), od3, 16'hA000 + 16'(j));
      chk($sformatf("s3 drain j%0d occupancy", j), oc3, (j <= 3) ? (6 - j) : 3);
      if (ir3) nacc++;
    end
    @(negedge clk); iv3 = 1'b0;

    // 2-stage random traffic with toggling out_ready against a scoreboard
    @(negedge clk); f2 = 1'b1; iv2 = 1'b0; or2 = 1'b0;
    hold_prev = 1'b0; held = '0;
    for (int c = 0; c < 212; c++) begin
      @(negedge clk);
      f2 = 1'b0;
      iv2 = (c < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
      id2 = 8'($urandom);
      or2 = (c < 200) ? c[0] : 1'b1;
      #1;
      if (hold_prev) begin
        chk("sb hold out_valid", ov2, 1);
        chk("sb hold out_data", od2, held);
      end
      chk("sb occupancy", oc2, q.size());
      if (ov2 && or2) begin
        if (q.size() == 0) chk("sb extra beat", ov2, 0);
        else chk("sb out_data", od2, q.pop_front());
      end
      if (iv2 && ir2) q.push_back(id2);
      hold_prev = ov2 && !or2;
      held = od2;
    end
    @(negedge clk);
    #1;
    chk("sb drained model", q.size(), 0);
    chk("sb drained out_valid", ov2, 0);
    chk("sb drained occupancy", oc2, 0);

    // asynchronous reset mid-stream
    @(negedge clk); iv2 = 1'b1; id2 = 8'hC1; or2 = 1'b0;
    @(negedge clk); id2 = 8'hC2;
    @(posedge clk);
    #2;
    chk("pre-reset out_valid", ov2, 1);
    rst = 1'b0;
    #1;
    chk("async reset s2 out_valid", ov2, 0);
    chk("async reset s2 occupancy", oc2, 0);
    chk("async reset s2 out_data", od2, 0);
    chk("async reset s2 in_ready", ir2, 1);
    chk("async reset s1 out_data", od1, 8'hFF);
    @(negedge clk); rst = 1'b1; iv2 = 1'b0;
    @(negedge clk); iv2 = 1'b1; id2 = 8'hD7; or2 = 1'b1;
    #1;
    chk("post-reset lat c0", ov2, 0);
    @(negedge clk); iv2 = 1'b0;
    #1;
    chk("post-reset lat c1", ov2, 0);
    @(negedge clk);
    #1;
    chk("post-reset lat c2 out_valid", ov2, 1);
    chk("post-reset lat c2 out_data", od2, 8'hD7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
